// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cache-line to memory-burst adapter.
package cacheline_adapter_pkg;

    localparam int LINE_W           = 256;
    localparam int BEAT_W           = 64;
    localparam int BEATS            = 4;
    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        RESP
    } adapter_state_t;

    // Clear the byte-in-line offset so bursts always start on a line boundary.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Turns single-line cache reads/writes into 4-beat 64-bit bursts on the
// banked-memory port and returns a one-cycle completion pulse to the cache.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic [31:0]         dfp_addr,
    input  logic                dfp_read,
    input  logic                dfp_write,
    input  logic [LINE_W-1:0]   dfp_wdata,
    output logic [LINE_W-1:0]   dfp_rdata,
    output logic                dfp_resp,

    output logic [31:0]         bmem_addr,
    output logic                bmem_read,
    output logic                bmem_write,
    output logic [BEAT_W-1:0]   bmem_wdata,
    input  logic                bmem_ready,
    input  logic [31:0]         bmem_raddr,
    input  logic [BEAT_W-1:0]   bmem_rdata,
    input  logic                bmem_rvalid
);

    adapter_state_t    state, next;
    logic [1:0]        beat;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] line_q;
    logic              beat_hit;
    logic              wr_acc;

    assign beat_hit = (state == RD_DATA) && bmem_rvalid && (bmem_raddr == addr_q);
    assign wr_acc   = (state == WR_DATA) && bmem_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (dfp_write)     next = WR_DATA;
                else if (dfp_read) next = RD_REQ;
            end
            RD_REQ:  if (bmem_ready)                 next = RD_DATA;
            RD_DATA: if (beat_hit && beat == 2'd3)   next = RESP;
            WR_DATA: if (wr_acc && beat == 2'd3)     next = RESP;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        case (state)
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
            end
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = line_q[beat*BEAT_W +: BEAT_W];
            end
            RESP:    dfp_resp = 1'b1;
            default: ;
        endcase
    end

    // line_q doubles as write staging and read assembly; dfp_rdata only updates
    // when a read completes so it holds steady across writes and partial reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            dfp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (dfp_write) begin
                        addr_q <= line_base(dfp_addr);
                        line_q <= dfp_wdata;
                    end else if (dfp_read) begin
                        addr_q <= line_base(dfp_addr);
                    end
                end
                RD_DATA: begin
                    if (beat_hit) begin
                        line_q[beat*BEAT_W +: BEAT_W] <= bmem_rdata;
                        beat <= beat + 2'd1;
                        if (beat == 2'd3)
                            dfp_rdata <= {bmem_rdata, line_q[LINE_W-BEAT_W-1:0]};
                    end
                end
                WR_DATA: if (bmem_ready) beat <= beat + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Responder for the cache's 256-bit line port (`dfp_*`). It converts each line read or line write into a 4-beat, 64-bit burst on the banked-memory port (`bmem_*`). The block sits between one cache instance and main memory, so the cache sees a single-request, single-response line interface. It assembles read beats into a line, serialises write lines into beats, and returns a one-cycle `dfp_resp`.

## Interface
- No parameters. Line width 256 b, beat width 64 b and 4 beats per line are fixed package constants.
- Clock and reset:
  - `clk  in  1` — single clock, rising edge.
  - `rst  in  1` — synchronous, active-high reset.
- Cache-side (`dfp_*`) ports:
  - `dfp_addr  in  32` — line address; bits [4:0] are ignored and forced to 0.
  - `dfp_read  in  1` — level request, held by the cache until `dfp_resp`.
  - `dfp_write  in  1` — level request, held by the cache until `dfp_resp`.
  - `dfp_wdata  in  256` — line to write; stable while `dfp_write` is high.
  - `dfp_rdata  out  256` — assembled read line; registered.
  - `dfp_resp  out  1` — one-cycle completion pulse.
- Memory-side (`bmem_*`) ports:
  - `bmem_addr  out  32` — burst base address, 32-byte aligned.
  - `bmem_read  out  1` — read command, 1 cycle.
  - `bmem_write  out  1` — write beat valid.
  - `bmem_wdata  out  64` — write beat; beat 0 = line bits [63:0].
  - `bmem_ready  in  1` — memory accepts a command or write beat this cycle.
  - `bmem_raddr  in  32` — address tag of the returning read beat.
  - `bmem_rdata  in  64` — read beat data.
  - `bmem_rvalid  in  1` — read beat valid.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
- IDLE:
  - `dfp_write` high → latch addr and wdata, go to WR_DATA.
  - Else `dfp_read` high → latch addr, go to RD_REQ.
  - If both are high, write wins (the cache never does this; covered for robustness).
- RD_REQ:
  - Drive `bmem_read`=1 and `bmem_addr`=latched addr.
  - Stay in RD_REQ until `bmem_ready`=1; go to RD_DATA on that cycle.
- RD_DATA:
  - Each cycle with `bmem_rvalid`=1 and `bmem_raddr`=latched addr, write `bmem_rdata` into line slice [beat*64 +: 64] and increment a 2-bit beat counter.
  - Beats with a mismatched `raddr` are ignored.
  - Gaps between beats are allowed.
  - After beat 3 is captured, go to RESP.
- WR_DATA:
  - Drive `bmem_write`=1, `bmem_addr`=latched addr, `bmem_wdata`=latched line [beat*64 +: 64].
  - The beat counter advances only on `bmem_ready`=1; while ready is low, the current beat is held.
  - Beat 3 accepted → RESP.
- RESP:
  - `dfp_resp`=1 for exactly one cycle, then IDLE.
  - `dfp_rdata` is valid in RESP and holds until the next read's RESP; a write leaves it untouched.
- Request sampling:
  - The request is sampled only in IDLE.
  - The still-asserted request during RESP is ignored.
  - The cycle after RESP is IDLE, so a request present then (e.g. an allocate read right after a writeback) starts immediately.
- Outputs in IDLE and RESP: `bmem_read`=`bmem_write`=0, `bmem_addr`=0, `bmem_wdata`=0.
- Beats with `bmem_rvalid`=1 outside RD_DATA are ignored.

## Timing
- Reset values:
  - State = IDLE, beat counter = 0.
  - `dfp_resp`=0, `dfp_rdata`=0.
  - `bmem_read`=0, `bmem_write`=0, `bmem_addr`=0, `bmem_wdata`=0.
- Reset mid-burst: abandon the burst, return to IDLE, and emit no `dfp_resp`. Late read beats are ignored.
- Read latency (request seen in IDLE at cycle 0):
  - `bmem_read` from cycle 1 until ready.
  - If the last beat is captured at cycle k, `dfp_resp` is at k+1.
- Write latency (request at cycle 0, `bmem_ready` constantly high): beats at cycles 1–4, `dfp_resp` at cycle 5.
- Each ready-low cycle adds one cycle to the write.
- Minimum gap between back-to-back requests: one IDLE cycle after RESP.

## Structure
- Shared types package:
  - `adapter_state_t` enum.
  - `LINE_W`=256, `BEAT_W`=64, `BEATS`=4.
  - `LINE_OFFSET_BITS`=5.
- Single flat module; no sub-module is warranted. The line register, 2-bit counter and FSM are all local.

## Test plan
- Read, beats back-to-back:
  - Stimulus: `dfp_read` to 0x0000_1234; beats 0xA0..0xA3 (64-bit) on 4 consecutive cycles after `bmem_ready`.
  - Response: `bmem_addr`=0x0000_1220 on a 1-cycle `bmem_read`; `dfp_rdata`={A3,A2,A1,A0}; single `dfp_resp` the cycle after beat 3.
- Read, gaps and foreign beats:
  - Stimulus: beats separated by 2 idle cycles, plus one beat with `raddr`=0x40.
  - Response: the foreign beat is ignored; the line is correct; `dfp_resp` follows the 4th matching beat.
- Write with backpressure:
  - Stimulus: `dfp_write` of line W to 0x80; `bmem_ready` low on cycle 2 only.
  - Response: beats W[63:0]..W[255:192], beat 1 held for 2 cycles; `dfp_resp` at cycle 6.
- Writeback then allocate:
  - Stimulus: `dfp_write` completes, `dfp_read` asserted the next cycle; the cache keeps `dfp_write` high during the RESP cycle.
  - Response: no second write; the read starts from IDLE; exactly one `dfp_resp` per request.
- Reset mid-read:
  - Stimulus: `rst` after 2 of 4 beats, then beats 2–3 still arrive.
  - Response: FSM in IDLE, `dfp_resp` never asserted, all outputs at reset values.
